// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a trial value into an external
// magnitude comparator and binary-searches the target from the returned gt/eq/lt flags.
module sar_search #(
  parameter int W     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     trial,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] probes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] MAX_VAL   = {W{1'b1}};
  localparam logic [W-1:0] FIRST_MID = MAX_VAL >> 1;

  state_t     state;
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  // Midpoints are formed in W+1 bits so lo+hi never wraps, even at the top of the range.
  logic [W:0]   up_sum;
  logic [W:0]   dn_sum;
  logic [W-1:0] trial_inc;
  logic [W-1:0] trial_dec;
  logic [2:0]   flags;

  assign trial_inc = trial + W'(1);
  assign trial_dec = trial - W'(1);
  assign up_sum    = {1'b0, trial_inc} + {1'b0, hi};
  assign dn_sum    = {1'b0, lo} + {1'b0, trial_dec};
  assign flags     = {cmp_gt, cmp_eq, cmp_lt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      lo     <= '0;
      hi     <= '0;
      result <= '0;
      probes <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= MAX_VAL;
            trial  <= FIRST_MID;
            probes <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= PROBE;
          end else begin
            state <= IDLE;
          end
        end

        PROBE: begin
          probes <= probes + CNT_W'(1);
          case (flags)
            3'b010: begin
              found  <= 1'b1;
              result <= trial;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
            3'b100: begin
              // Target claimed above a trial that is already the upper bound: inconsistent.
              if (trial == hi) begin
                err    <= 1'b1;
                result <= trial;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                lo    <= trial_inc;
                trial <= up_sum[W:1];
              end
            end
            3'b001: begin
              if (trial == lo) begin
                err    <= 1'b1;
                result <= trial;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                hi    <= trial_dec;
                trial <= dn_sum[W:1];
              end
            end
            default: begin
              err    <= 1'b1;
              result <= trial;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          endcase
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural comparator answers each trial and
// expected trial sequences / completion results are queued at launch and popped on output.
module tb_sar_search;

  localparam int W     = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic       found;
    logic       err;
    logic [7:0] result;
    logic [7:0] probes;
  } exp_res_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     trial;
  logic             cmp_gt, cmp_eq, cmp_lt;
  logic             busy, done, found, err;
  logic [W-1:0]     result;
  logic [CNT_W-1:0] probes;

  int        target;
  int        mode;   // 0 ideal, 1 tied gt, 2 tied lt, 3 gt and lt together
  int        n_checks;
  int        n_errors;
  int        busy_cnt;
  int        exp_trial_q[$];
  exp_res_t  exp_res_q[$];

  sar_search #(.W(W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .trial  (trial),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cmp_gt = 1'b0;
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    case (mode)
      0: begin
        cmp_gt = (target > int'(trial));
        cmp_eq = (target == int'(trial));
        cmp_lt = (target < int'(trial));
      end
      1: cmp_gt = 1'b1;
      2: cmp_lt = 1'b1;
      default: begin
        cmp_gt = 1'b1;
        cmp_lt = 1'b1;
      end
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: trials checked every probe cycle, results checked on the done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        busy_cnt++;
        if (exp_trial_q.size() == 0)
          check("trial_extra", int'(trial), -1);
        else
          check("trial", int'(trial), exp_trial_q.pop_front());
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_res_t e;
          e = exp_res_q.pop_front();
          check("found", int'(found), int'(e.found));
          check("err", int'(err), int'(e.err));
          check("result", int'(result), int'(e.result));
          check("probes", int'(probes), int'(e.probes));
          check("busy_cycles", busy_cnt, int'(e.probes));
          check("busy_at_done", int'(busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic launch(input int tgt, input int md, input int seq[$],
                        input logic f, input logic e, input int res);
    exp_res_t r;
    target = tgt;
    mode   = md;
    foreach (seq[i]) exp_trial_q.push_back(seq[i]);
    r.found  = f;
    r.err    = e;
    r.result = 8'(res);
    r.probes = 8'(seq.size());
    exp_res_q.push_back(r);
    start = 1'b1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic run_one(input int tgt, input int md, input int seq[$],
                         input logic f, input logic e, input int res);
    launch(tgt, md, seq, f, e, res);
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    wait_done();
  endtask

  function automatic void ideal_seq(input int tgt, output int seq[$]);
    int l, h, t;
    seq.delete();
    l = 0;
    h = (1 << W) - 1;
    forever begin
      t = (l + h) / 2;
      seq.push_back(t);
      if (t == tgt) break;
      if (tgt > t) l = t + 1;
      else         h = t - 1;
    end
  endfunction

  initial begin
    int seq[$];
    n_checks = 0;
    n_errors = 0;
    busy_cnt = 0;
    target   = 0;
    mode     = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    check("rst_trial", int'(trial), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_err", int'(err), 0);
    check("rst_result", int'(result), 0);
    check("rst_probes", int'(probes), 0);

    run_one(11, 0, '{7, 11}, 1'b1, 1'b0, 11);
    @(posedge clk); #2;
    check("found_held", int'(found), 1);
    check("done_one_cycle", int'(done), 0);
    check("trial_held", int'(trial), 11);

    run_one(15, 0, '{7, 11, 13, 14, 15}, 1'b1, 1'b0, 15);
    @(posedge clk); #2;
    run_one(0, 0, '{7, 3, 1, 0}, 1'b1, 1'b0, 0);
    @(posedge clk); #2;

    // Inconsistent flags on the first probe.
    run_one(5, 3, '{7}, 1'b0, 1'b1, 7);
    @(posedge clk); #2;
    check("err_held", int'(err), 1);
    run_one(0, 1, '{7, 11, 13, 14, 15}, 1'b0, 1'b1, 15);
    @(posedge clk); #2;
    run_one(0, 2, '{7, 3, 1, 0}, 1'b0, 1'b1, 0);
    @(posedge clk); #2;

    // Exhaustive sweep, each new start issued in the previous DONE cycle.
    for (int t = 0; t < (1 << W); t++) begin
      ideal_seq(t, seq);
      run_one(t, 0, seq, 1'b1, 1'b0, t);
    end
    @(posedge clk); #2;

    // Start while busy must be ignored.
    launch(13, 0, '{7, 11, 13}, 1'b1, 1'b0, 13);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("trial_ignore_start", int'(trial), 11);
    start = 1'b0;
    wait_done();
    @(posedge clk); #2;

    // Reset during the second probe of target 11.
    target = 11;
    mode   = 0;
    exp_trial_q.push_back(7);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    check("mid_trial", int'(trial), 11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_trial", int'(trial), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_found", int'(found), 0);
    check("mid_rst_probes", int'(probes), 0);
    check("mid_rst_result", int'(result), 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_no_done", int'(done), 0);
    end
    check("rst_queue_empty", exp_trial_q.size(), 0);
    exp_trial_q.delete();
    exp_res_q.delete();
    busy_cnt = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_rst_done", int'(done), 0);
    run_one(11, 0, '{7, 11}, 1'b1, 1'b0, 11);
    @(posedge clk); #2;
    check("final_queue_empty", exp_res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller. It is the initiator side of a magnitude comparator: it drives a trial value into an external comparator and uses that comparator's gt/eq/lt flags to binary-search for an unknown target.
- The comparator compares target against trial and returns flags combinationally in the same cycle.
- Used for threshold finding and for self-check of comparator blocks.

Parameters:
- W, 4, operand/trial width in bits.
- CNT_W, 3, width of the probe counter; must satisfy 2^CNT_W > W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new search; sampled in IDLE or DONE, ignored while busy.
- trial  output  W  registered value presented to the comparator.
- cmp_gt  input  1  target > trial.
- cmp_eq  input  1  target == trial.
- cmp_lt  input  1  target < trial.
- busy  output  1  high in PROBE.
- done  output  1  one-cycle pulse on completion (success or error).
- found  output  1  last search ended on cmp_eq; held until next start.
- err  output  1  last search ended on inconsistent flags; held until next start.
- result  output  W  trial value at completion; held until next start.
- probes  output  CNT_W  number of probes used by the last or current search.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; trial, result, probes, lo, hi = 0; busy, done, found, err = 0.
- Internal registers: lo and hi (W bits each). Midpoint arithmetic uses W+1 bits: mid = (lo+hi)>>1. No overflow is permitted.
- States: IDLE, PROBE, DONE.
- IDLE/DONE, start=1 at a clock edge:
  - lo=0, hi=2^W-1, trial=(2^W-1)>>1, probes=0.
  - found=0, err=0; state=PROBE.
  - DONE otherwise returns to IDLE after one cycle.
- PROBE, at each edge:
  - Flags are sampled; probes increments by 1.
  - Exactly cmp_eq: result=trial, found=1, state=DONE.
  - Exactly cmp_gt:
    - trial==hi → err=1, result=trial, state=DONE.
    - else lo=trial+1, trial=mid(trial+1, hi), stay in PROBE.
  - Exactly cmp_lt:
    - trial==lo → err=1, result=trial, state=DONE.
    - else hi=trial-1, trial=mid(lo, trial-1), stay in PROBE.
  - Zero or more than one flag set → err=1, result=trial, state=DONE.
- done=1 only during the single DONE cycle. busy=1 exactly while state=PROBE.
- A start asserted during PROBE has no effect.
- trial holds its last value in IDLE/DONE.
- Latency: a consistent comparator completes in at most W+1 probes. done rises W+1 edges or fewer after the edge that accepted start.
- Boundaries:
  - Target 0 and target 2^W-1 must be reachable without underflow or overflow.
  - Back-to-back: start in the DONE cycle begins a new search immediately (no IDLE cycle).
- Reset mid-search: all outputs return to reset values immediately. No done pulse is produced.

Test Plan:
- W=4, ideal comparator, target=11, pulse start: trial sequence 7, 11 → done after 2nd probe; found=1, result=11, probes=2, err=0.
- Target=15: trial 7, 11, 13, 14, 15 → found=1, result=15, probes=5. Target=0: trial 7, 3, 1, 0 → result=0, probes=4.
- Exhaustive sweep of targets 0..15 with back-to-back start in each DONE cycle: every search gives found=1, result==target, probes≤5, busy never low mid-search.
- Force flags cmp_gt=1 and cmp_lt=1 on the first probe: done on the next edge; err=1, found=0, result=7, probes=1.
- Comparator tied to cmp_gt=1 always: trial 7, 11, 13, 14, 15, then err=1, result=15, probes=5. Tied to cmp_lt=1 always: ends at trial 0 with err=1.
- Deassert rst_n during the 2nd probe of target=11: outputs immediately 0, state IDLE, no done pulse. start after release gives a correct result=11.
